// File: rtl/conv_stream_tx.sv
// conv_stream_tx: kernel coefficient bank plus pixel FIFO that feeds a convolver, kernel first, then one frame of pixels.
// Optional feature macro CONV_TX_UNDERRUN_ABORT_EN: abort the frame on pixel underrun instead of stalling.
module conv_stream_tx #(
  parameter int unsigned BITS         = 9,
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned FRAME_PIXELS = 256
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_valid,
  input  logic                          wr_sel,
  input  logic [BITS-1:0]               wr_data,
  output logic                          wr_ready,
  input  logic                          start,
  output logic                          kernel_write_en,
  output logic [BITS-1:0]               kernel_out,
  output logic                          img_write_en,
  output logic [BITS-1:0]               img_out,
  output logic                          busy,
  output logic                          done,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned K   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned KIW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned KCW = $clog2(K + 1);
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW  = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {IDLE, KLOAD, FILL, STREAM, DONE} state_t;

  state_t          state;
  logic [BITS-1:0] kbank [K];
  logic [KIW-1:0]  kidx;
  logic [KCW-1:0]  kcnt;
  logic [BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [15:0]     pix_cnt;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic kwr;
  logic last_pix;
  logic fill_ok;

  // Kernel writes are blocked only while the bank is being streamed out; pixel writes only when full.
  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign wr_ready   = wr_sel ? (state != KLOAD) : !fifo_full;
  assign push       = wr_valid && wr_ready && !wr_sel;
  assign kwr        = wr_valid && wr_ready && wr_sel;
  assign pop        = (state == STREAM) && !fifo_empty;
  assign last_pix   = (pix_cnt == 16'(FRAME_PIXELS - 1));
  assign fill_ok    = fifo_full || (32'(fifo_level) >= (32'(FRAME_PIXELS) - 32'(pix_cnt)));

`ifndef CONV_TX_UNDERRUN_ABORT_EN
  assign underrun = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      kidx            <= '0;
      kcnt            <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_level      <= '0;
      pix_cnt         <= '0;
      kernel_write_en <= 1'b0;
      kernel_out      <= '0;
      img_write_en    <= 1'b0;
      img_out         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
`ifdef CONV_TX_UNDERRUN_ABORT_EN
      underrun        <= 1'b0;
`endif
      for (int i = 0; i < int'(K); i++) kbank[i] <= '0;
    end else begin
      kernel_write_en <= 1'b0;
      img_write_en    <= 1'b0;
      done            <= 1'b0;

      if (kwr) begin
        kbank[kidx] <= wr_data;
        kidx        <= (kidx == KIW'(K - 1)) ? '0 : kidx + KIW'(1);
      end

      if (push) begin
        fifo_mem[wr_ptr] <= wr_data;
        wr_ptr           <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end

      // A popped pixel appears on img_out the cycle after it leaves the FIFO.
      if (pop) begin
        rd_ptr       <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        img_out      <= fifo_mem[rd_ptr];
        img_write_en <= 1'b1;
        pix_cnt      <= pix_cnt + 16'd1;
      end

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            state           <= KLOAD;
            busy            <= 1'b1;
            kernel_write_en <= 1'b1;
            kernel_out      <= kbank[0];
            kcnt            <= KCW'(1);
            pix_cnt         <= '0;
          end
        end
        KLOAD: begin
          if (kcnt == KCW'(K)) begin
            state <= FILL;
          end else begin
            kernel_write_en <= 1'b1;
            kernel_out      <= kbank[KIW'(kcnt)];
            kcnt            <= kcnt + KCW'(1);
          end
        end
        FILL: begin
          if (fill_ok) state <= STREAM;
        end
        STREAM: begin
          if (pop && last_pix) begin
            state <= DONE;
            done  <= 1'b1;
          end
`ifdef CONV_TX_UNDERRUN_ABORT_EN
          if (fifo_empty) begin
            underrun <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_tx.sv
// tb_conv_stream_tx: randomized self-checking bench for conv_stream_tx against an array/queue model.
// Underrun expectations follow the CONV_TX_UNDERRUN_ABORT_EN build.
`timescale 1ns/1ps
module tb_conv_stream_tx;

  localparam int unsigned BITS  = 9;
  localparam int unsigned K     = 9;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned FRAME = 256;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic            clk      = 1'b0;
  logic            reset_n  = 1'b0;
  logic            wr_valid = 1'b0;
  logic            wr_sel   = 1'b0;
  logic            start    = 1'b0;
  logic [BITS-1:0] wr_data  = '0;
  logic            wr_ready, kernel_write_en, img_write_en, busy, done, underrun;
  logic [BITS-1:0] kernel_out, img_out;
  logic [LW-1:0]   fifo_level;
  logic            wr_ready4, kwe4, iwe4, busy4, done4, underrun4;
  logic [BITS-1:0] kout4, iout4;
  logic [LW-1:0]   level4;

  conv_stream_tx #(.BITS(BITS), .KERNEL_SIZE(3), .FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FRAME)) u_dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_ready(wr_ready), .start(start), .kernel_write_en(kernel_write_en), .kernel_out(kernel_out),
    .img_write_en(img_write_en), .img_out(img_out), .busy(busy), .done(done),
    .underrun(underrun), .fifo_level(fifo_level)
  );

  // Short-frame instance shares the stimulus; it is only checked in its own scenario.
  conv_stream_tx #(.BITS(BITS), .KERNEL_SIZE(3), .FIFO_DEPTH(DEPTH), .FRAME_PIXELS(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_ready(wr_ready4), .start(start), .kernel_write_en(kwe4), .kernel_out(kout4),
    .img_write_en(iwe4), .img_out(iout4), .busy(busy4), .done(done4),
    .underrun(underrun4), .fifo_level(level4)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int kq[$], kcyc[$], iq[$], icyc[$], i4q[$], i4cyc[$];
  int done_n = 0, done_img = 0, done4_n = 0;

  always @(negedge clk) begin
    if (kernel_write_en) begin kq.push_back(int'(kernel_out)); kcyc.push_back(cyc); end
    if (img_write_en)    begin iq.push_back(int'(img_out));    icyc.push_back(cyc); end
    if (done)            begin done_n++; done_img = iq.size(); end
    if (iwe4)            begin i4q.push_back(int'(iout4)); i4cyc.push_back(cyc); end
    if (done4)           done4_n++;
  end

  // Reference model: kernel bank with wrapping write index, and the pixel sequence offered to the host port.
  int kb[K];
  int kptr = 0;
  int pix_vals[FRAME];
  bit feed_on = 0, feed_rand = 0;
  int feed_sent = 0, feed_limit = 0;
  int start_cyc = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    if (feed_on) begin
      wr_sel = 1'b0;
      if (feed_sent < feed_limit && (!feed_rand || $urandom_range(0, 3) != 0)) begin
        wr_valid = 1'b1;
        wr_data  = BITS'(pix_vals[feed_sent]);
      end else begin
        wr_valid = 1'b0;
      end
    end
    @(negedge clk);
    if (feed_on && wr_valid && wr_ready && !wr_sel) feed_sent++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    feed_on = 0; wr_valid = 0; wr_sel = 0; start = 0; reset_n = 0;
    step(); step();
    reset_n = 1;
    for (int i = 0; i < int'(K); i++) kb[i] = 0;
    kptr = 0;
  endtask

  task automatic kwrite(input int v);
    wr_valid = 1; wr_sel = 1; wr_data = BITS'(v);
    @(negedge clk);
    check("kwr_ready", int'(wr_ready), 1);
    @(posedge clk);
    #1;
    wr_valid = 0; wr_sel = 0;
    kb[kptr] = v;
    kptr = (kptr + 1) % int'(K);
  endtask

  task automatic kick();
    start = 1; step(); start = 0;
    start_cyc = cyc;
  endtask

  task automatic fill_vals(input bit rnd);
    for (int i = 0; i < int'(FRAME); i++) pix_vals[i] = rnd ? int'($urandom_range(0, 511)) : (i % 256);
  endtask

  task automatic feed(input int limit, input bit rnd);
    feed_on = 1; feed_sent = 0; feed_limit = limit; feed_rand = rnd;
  endtask

  task automatic wait_full(input int budget);
    for (int n = 0; n < budget && fifo_level != LW'(DEPTH); n++) step();
    check("prefill_level", int'(fifo_level), int'(DEPTH));
  endtask

  task automatic run_until_done(input int ib0, input int budget);
    int d0 = done_n;
    for (int n = 0; n < budget && done_n == d0; n++) step();
    repeat (3) step();
    check("done_pulses", done_n - d0, 1);
    check("done_after_last_pixel", done_img - ib0, int'(FRAME));
  endtask

  task automatic check_kernel(input int kb0);
    check("k_count", kq.size() - kb0, int'(K));
    for (int i = 0; i < int'(K) && kb0 + i < kq.size(); i++) begin
      check($sformatf("k_val%0d", i), kq[kb0 + i], kb[i]);
      check($sformatf("k_cyc%0d", i), kcyc[kb0 + i], start_cyc + i);
    end
  endtask

  task automatic check_img(input int ib0, input int n, input bit nogap, output int gaps);
    gaps = 0;
    check("img_count", iq.size() - ib0, n);
    for (int i = 0; i < n && ib0 + i < iq.size(); i++) begin
      check($sformatf("img_val%0d", i), iq[ib0 + i], pix_vals[i]);
      if (i > 0 && icyc[ib0 + i] - icyc[ib0 + i - 1] != 1) gaps++;
    end
    if (nogap) check("img_gaps", gaps, 0);
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_kwe"},   int'(kernel_write_en), 0);
    check({p, "_kout"},  int'(kernel_out), 0);
    check({p, "_iwe"},   int'(img_write_en), 0);
    check({p, "_iout"},  int'(img_out), 0);
    check({p, "_busy"},  int'(busy), 0);
    check({p, "_done"},  int'(done), 0);
    check({p, "_urun"},  int'(underrun), 0);
    check({p, "_level"}, int'(fifo_level), 0);
    check({p, "_ready"}, int'(wr_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kb0, ib0, d0, gaps, nk;
    bit nogap_rand;

    // Reset values.
    do_reset();
    check_reset_vals("rst");

    // Kernel 1..9, pixels n mod 256, continuous supply.
    for (int i = 1; i <= 9; i++) kwrite(i);
    fill_vals(0);
    feed(FRAME, 0);
    wait_full(100);
    check("full_ready", int'(wr_ready), 0);
    kb0 = kq.size(); ib0 = iq.size();
    kick();
    check("busy_kload", int'(busy), 1);
    run_until_done(ib0, 1000);
    check_kernel(kb0);
    check_img(ib0, FRAME, 1, gaps);
    check("busy_after", int'(busy), 0);
    check("level_after", int'(fifo_level), 0);

    // Ten kernel writes wrap onto entry 0; random pixel values.
    do_reset();
    for (int i = 1; i <= 10; i++) kwrite(i);
    fill_vals(1);
    feed(FRAME, 0);
    kb0 = kq.size(); ib0 = iq.size();
    kick();
    run_until_done(ib0, 1000);
    check_kernel(kb0);
    check_img(ib0, FRAME, 1, gaps);

    // Random kernel count/values, random pixels, random host stalls.
    do_reset();
    nk = int'($urandom_range(1, 20));
    for (int i = 0; i < nk; i++) kwrite(int'($urandom_range(0, 511)));
    fill_vals(1);
    feed(FRAME, 1);
    wait_full(300);
    nogap_rand = 0;
`ifdef CONV_TX_UNDERRUN_ABORT_EN
    feed_rand  = 0;
    nogap_rand = 1;
`endif
    kb0 = kq.size(); ib0 = iq.size();
    kick();
    run_until_done(ib0, 2000);
    check_kernel(kb0);
    check_img(ib0, FRAME, nogap_rand, gaps);

    // Full FIFO: 17th write dropped, push blocked on the first pop.
    do_reset();
    fill_vals(1);
    for (int i = 0; i < int'(DEPTH); i++) begin
      wr_valid = 1; wr_sel = 0; wr_data = BITS'(pix_vals[i]);
      step();
    end
    check("full16_level", int'(fifo_level), int'(DEPTH));
    check("full16_ready", int'(wr_ready), 0);
    wr_data = BITS'(9'h1AA);
    step();
    check("full17_level", int'(fifo_level), int'(DEPTH));
    wr_data = BITS'(9'h0F0);
    ib0 = iq.size();
    kick();
    for (int n = 0; n < 40 && iq.size() == ib0; n++) step();
    check("pushpop_level", int'(fifo_level), int'(DEPTH) - 1);
    repeat (20) step();
    check("pp_count_ok", int'(iq.size() - ib0 >= 17), 1);
    if (iq.size() - ib0 >= 17) begin
      for (int i = 0; i < int'(DEPTH); i++) check($sformatf("pp_val%0d", i), iq[ib0 + i], pix_vals[i]);
      check("pp_after_drop", iq[ib0 + 16], 'h0F0);
    end
    wr_valid = 0;

    // Supply stops after 20 pixels of the frame.
    do_reset();
    for (int i = 1; i <= 9; i++) kwrite(i);
    fill_vals(1);
    feed(20, 0);
    ib0 = iq.size(); d0 = done_n;
    kick();
`ifdef CONV_TX_UNDERRUN_ABORT_EN
    for (int n = 0; n < 300 && busy; n++) step();
    repeat (5) step();
    check("urun_flag", int'(underrun), 1);
    check("urun_busy", int'(busy), 0);
    check("urun_no_done", done_n - d0, 0);
    check("urun_count", iq.size() - ib0, 20);
    check("urun_iwe", int'(img_write_en), 0);
`else
    repeat (80) step();
    check("stall_busy", int'(busy), 1);
    check("stall_urun", int'(underrun), 0);
    check("stall_count", iq.size() - ib0, 20);
    check("stall_iwe", int'(img_write_en), 0);
    feed_limit = FRAME;
    run_until_done(ib0, 1000);
    check_img(ib0, FRAME, 0, gaps);
    check("stall_gap_seen", int'(gaps > 0), 1);
    check("stall_busy_end", int'(busy), 0);
`endif

    // Extra start pulses during KLOAD, then reset mid-stream.
    do_reset();
    check_reset_vals("rst2");
    for (int i = 1; i <= 9; i++) kwrite(i);
    fill_vals(0);
    feed(FRAME, 0);
    kb0 = kq.size(); ib0 = iq.size(); d0 = done_n;
    kick();
    repeat (2) begin start = 1; step(); start = 0; step(); end
    for (int n = 0; n < 300 && iq.size() < ib0 + 30; n++) step();
    check("mid_streaming", int'(iq.size() >= ib0 + 30), 1);
    check("no_second_kload", kq.size() - kb0, int'(K));
    do_reset();
    repeat (5) step();
    check_reset_vals("rst3");
    check("rst3_no_done", done_n - d0, 0);
    check("rst3_no_restart", kq.size() - kb0, int'(K));

    // Four-pixel frame on the short instance; bank still zero after reset.
    do_reset();
    fill_vals(1);
    feed(4, 0);
    for (int n = 0; n < 20 && level4 != LW'(4); n++) step();
    check("f4_level", int'(level4), 4);
    kb0 = kq.size(); ib0 = i4q.size(); d0 = done4_n;
    kick();
    for (int n = 0; n < 100 && done4_n == d0; n++) step();
    repeat (5) step();
    check_kernel(kb0);
    check("f4_count", i4q.size() - ib0, 4);
    if (i4q.size() - ib0 == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("f4_val%0d", i), i4q[ib0 + i], pix_vals[i]);
      check("f4_span", i4cyc[ib0 + 3] - i4cyc[ib0], 3);
    end
    check("f4_done", done4_n - d0, 1);
    check("f4_busy", int'(busy4), 0);
    check("f4_level_end", int'(level4), 0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_stream_tx.md
CONV_STREAM_TX -- requirements
Module: conv_stream_tx

Interface
REQ-001 SHALL have parameter BITS, default 9, the width of one pixel or kernel coefficient.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3; the coefficient count is K = KERNEL_SIZE*KERNEL_SIZE.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, the pixel FIFO depth and the fill threshold.
REQ-004 SHALL have parameter FRAME_PIXELS, default 256, the number of pixels emitted per frame.
REQ-005 SHALL have port clk, input, width 1: the single clock, all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, width 1: synchronous, active-low reset.
REQ-007 SHALL have port wr_valid, input, width 1: host write request.
REQ-008 SHALL have port wr_sel, input, width 1: 0 = pixel write, 1 = kernel write.
REQ-009 SHALL have port wr_data, input, width BITS: write payload.
REQ-010 SHALL have port wr_ready, output, width 1: a write is accepted when wr_valid and wr_ready are both high.
REQ-011 SHALL have port start, input, width 1: frame start request.
REQ-012 SHALL have port kernel_write_en / kernel_out, outputs, widths 1 / BITS: coefficient stream to the convolver.
REQ-013 SHALL have port img_write_en / img_out, outputs, widths 1 / BITS: pixel stream to the convolver.
REQ-014 SHALL have port busy, output, width 1: high whenever the state is not IDLE.
REQ-015 SHALL have port done, output, width 1: one-cycle pulse at frame completion.
REQ-016 SHALL have port underrun, output, width 1: sticky error flag.
REQ-017 SHALL have port fifo_level, output, width $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-018 SHALL hold a K-entry kernel bank; a kernel write stores into entry kidx, then kidx increments and wraps from K-1 to 0.
REQ-019 SHALL hold wr_ready low for kernel writes in KLOAD; for pixel writes, wr_ready SHALL equal (fifo_level != FIFO_DEPTH).
REQ-020 SHALL, on a simultaneous push and pop, leave fifo_level unchanged; a push is never accepted while the FIFO is full, even if a pop occurs in the same cycle.
REQ-021 SHALL implement the states IDLE, KLOAD, FILL, STREAM and DONE.
REQ-022 SHALL, in IDLE with start high, go to KLOAD; start outside IDLE SHALL be ignored.
REQ-023 SHALL, in KLOAD, register kernel_write_en=1 for exactly K consecutive cycles, with kernel_out = entry 0..K-1 in order; the first such cycle is the cycle after start is sampled. KLOAD then goes to FILL.
REQ-024 SHALL, in FILL, go to STREAM once fifo_level == FIFO_DEPTH, or once fifo_level >= the number of frame pixels remaining.
REQ-025 SHALL, in STREAM, pop one pixel per cycle and register it as img_out with img_write_en=1 in the following cycle, so every STREAM cycle produces one output pixel with no gaps.
REQ-026 SHALL keep a 16-bit pixel counter, cleared on entry to KLOAD; after pixel FRAME_PIXELS-1 is popped, the state SHALL go to DONE.
REQ-027 SHALL, in DONE, pulse done for one cycle and then return to IDLE.
REQ-028 SHALL drive img_write_en and kernel_write_en to 0 whenever they are not asserted as above; img_out and kernel_out hold their last values.
REQ-029 SHALL treat an empty FIFO in STREAM with pixels still remaining as an underrun, handled per Configuration.

Reset
REQ-030 SHALL, when reset_n is low at a clk edge, set state=IDLE, FIFO empty, kidx=0, all kernel entries 0, pixel counter 0, and every output 0 except wr_ready=1.
REQ-031 SHALL let reset mid-frame abort immediately, with no done pulse, and SHALL clear underrun.

Configuration
REQ-032 SHALL, with macro CONV_TX_UNDERRUN_ABORT_EN defined, on underrun set underrun=1 (held until reset), drop img_write_en, and go directly to IDLE without a done pulse.
REQ-033 SHALL, without CONV_TX_UNDERRUN_ABORT_EN, on underrun hold img_write_en=0 for that cycle, stay in STREAM, resume when data arrives, and tie underrun to 0.

Verification
REQ-034 Reset, then 9 kernel writes 1..9, then 256 pixel writes of value n mod 256 one per cycle, then start -> kernel_out 1..9 on 9 consecutive cycles; img_out 0,1,...,255 over 256 cycles with no gap; one done pulse; busy low after.
REQ-035 10 kernel writes 1..10 -> entry 0 holds 10, entries 1..8 hold 2..9; kernel_out emits 10,2,...,9.
REQ-036 16 pixel writes with no pops, then a 17th attempt -> fifo_level=16, wr_ready=0, 17th value dropped; push plus pop at level 16 -> level 15 after.
REQ-037 FRAME_PIXELS=4 with 4 pixels preloaded -> FILL exits at level 4; img_write_en high for exactly 4 cycles; done follows.
REQ-038 Stop the pixel supply after 20 pixels of a 256-pixel frame -> with the macro: underrun=1, busy=0, no done; without the macro: a gap in img_write_en, resume on refill, done after 256 pixels.
REQ-039 reset_n low during STREAM, and start pulses during KLOAD -> after reset, all outputs are at reset values and the FIFO is empty; extra start pulses cause no restart and no second KLOAD.
